merge_rr: RTL and testbench

// - N-master to 1-slave merge for the native bus: the inverse of the address-decoding splitter.
// - Arbitrates concurrent master requests round-robin and forwards one transaction at a time.
// - Routes the slave response only to the granted master.
// - Sits between the CPU instruction/data ports or DMA masters and a shared memory or peripheral.

---
 rtl/merge_rr_pkg.sv | 30 +++
 rtl/merge_rr_arbiter.sv | 38 +++
 rtl/merge_rr.sv | 91 +++++++++
 tb/tb_merge_rr.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_rr_pkg.sv
// Shared types and width helpers for the N-master to 1-slave round-robin merge.
package merge_rr_pkg;

  // Bus flavour: data bus carries {valid,addr,wdata,wstrb}, instruction bus {valid,addr}.
  typedef enum logic {
    BUS_D = 1'b0,
    BUS_I = 1'b1
  } bus_type_e;

  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  // Response is {rdata, ready}; ready sits in bit 0.
  localparam int BUS_RESP_W = DATA_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Request width for a bus flavour; valid is always the MSB.
  function automatic int bus_req_w(bus_type_e t, int addr_w);
    return (t == BUS_D) ? (1 + addr_w + DATA_W + STRB_W) : (1 + addr_w);
  endfunction

  // Index width for a set of n masters.
  function automatic int n_w(int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/merge_rr_arbiter.sv
// Combinational rotate-mask round-robin priority encoder.
// Scans last+1, last+2, ... (mod N) and reports the first requester.
module rr_arbiter
  import merge_rr_pkg::*;
#(
  parameter  int N = 2,
  localparam int W = n_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic         en,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  // One extra bit so last + i never overflows before the explicit wrap.
  logic [W:0] cand;

  // Pick the first requester after last; walking the scan backwards lets the nearest win.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise an unassigned path infers a latch.
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      // NOTE: blocking assignments here, because cand must be updated before it is used on the next line.
      cand = {1'b0, last} + (W+1)'(i);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      if (en && req[cand[W-1:0]]) begin
        gnt_idx = cand[W-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/merge_rr.sv
// N-master to 1-slave merge: round-robin arbitration, one transaction at a time,
// slave response routed only to the granted master.
module merge_rr
  import merge_rr_pkg::*;
#(
  parameter  bus_type_e TYPE      = BUS_D,
  parameter  int        N_MASTERS = 2,
  parameter  int        ADDR_W    = 32,
  localparam int        REQ_W     = bus_req_w(TYPE, ADDR_W),
  localparam int        IDX_W     = n_w(N_MASTERS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS*REQ_W-1:0]      m_req,
  output logic [N_MASTERS*BUS_RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]                s_req,
  input  logic [BUS_RESP_W-1:0]           s_resp
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q,  last_d;

  logic [N_MASTERS-1:0] m_valid;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;

  // Gather each master's valid bit (MSB of its request slice).
  always_comb begin
    m_valid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

  assign gnt_valid = m_valid[grant_q];

  // Arbitration only counts in IDLE, so a new grant is always decided in a fresh IDLE cycle.
  rr_arbiter #(
    .N(N_MASTERS)
  ) u_arb (
    .req    (m_valid),
    .last   (last_q),
    .en     (state_q == ST_IDLE),
    .gnt_idx(arb_idx),
    .gnt_vld(arb_vld)
  );

  // State, grant and last registers; last resets to N-1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
    end else begin
      // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic plus request mux and response demux.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    s_req   = '0;
    m_resp  = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d = ST_BUSY;
          grant_d = arb_idx;
        end
      end
      ST_BUSY: begin
        s_req = m_req[int'(grant_q)*REQ_W +: REQ_W];
        m_resp[int'(grant_q)*BUS_RESP_W +: BUS_RESP_W] = s_resp;
        // Leave on the slave's ready pulse or when the granted master aborts.
        if (s_resp[0] || !gnt_valid) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_merge_rr.sv
// Self-checking bench for merge_rr: directed scenarios on 2- and 3-master instances
// plus a randomized run against a transaction-level round-robin model.
module tb_merge_rr;
  import merge_rr_pkg::*;

  localparam int ADDR_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + 32 + 4;
  localparam int RESP_W = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_act;

  logic [REQ_W-1:0]  mreq [3];
  logic [RESP_W-1:0] sresp;

  logic [2*REQ_W-1:0]  m_req2;
  logic [2*RESP_W-1:0] m_resp2;
  logic [REQ_W-1:0]    s_req2;
  logic [RESP_W-1:0]   s_resp2;
  logic [3*REQ_W-1:0]  m_req3;
  logic [3*RESP_W-1:0] m_resp3;
  logic [REQ_W-1:0]    s_req3;
  logic [RESP_W-1:0]   s_resp3;

  logic [REQ_W-1:0]  obs_sreq;
  logic [RESP_W-1:0] obs_mresp [3];

  int total = 0;
  int bad   = 0;

  merge_rr #(.TYPE(BUS_D), .N_MASTERS(2), .ADDR_W(ADDR_W)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2), .s_req(s_req2), .s_resp(s_resp2)
  );

  merge_rr #(.TYPE(BUS_D), .N_MASTERS(3), .ADDR_W(ADDR_W)) dut3 (
    .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3), .s_req(s_req3), .s_resp(s_resp3)
  );

  // Only the active instance sees stimulus; the other idles on zeros.
  always_comb begin
    m_req2  = '0;
    m_req3  = '0;
    s_resp2 = '0;
    s_resp3 = '0;
    if (n_act == 3) begin
      m_req3  = {mreq[2], mreq[1], mreq[0]};
      s_resp3 = sresp;
    end else begin
      m_req2  = {mreq[1], mreq[0]};
      s_resp2 = sresp;
    end
  end

  always_comb begin
    obs_sreq     = '0;
    obs_mresp[0] = '0;
    obs_mresp[1] = '0;
    obs_mresp[2] = '0;
    if (n_act == 3) begin
      obs_sreq = s_req3;
      for (int i = 0; i < 3; i++) obs_mresp[i] = m_resp3[i*RESP_W +: RESP_W];
    end else begin
      obs_sreq     = s_req2;
      obs_mresp[0] = m_resp2[0 +: RESP_W];
      obs_mresp[1] = m_resp2[RESP_W +: RESP_W];
    end
  end

  function automatic logic [REQ_W-1:0] mk_req(logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
    return {1'b1, addr, wdata, wstrb};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(logic [31:0] rdata);
    return {rdata, 1'b1};
  endfunction

  function automatic logic [31:0] req_addr(logic [REQ_W-1:0] r);
    return r[REQ_W-2 -: ADDR_W];
  endfunction

  // Round-robin choice straight from the rule: first valid at last+1, last+2, ... mod n.
  function automatic int rr_pick(logic [2:0] v, int last, int n);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (last + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) mreq[i] = '0;
    sresp = '0;
  endtask

  task automatic do_reset(int n);
    n_act = n;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int n = 2; n <= 3; n++) begin
      n_act = n;
      rst   = 1'b1;
      for (int i = 0; i < 3; i++) mreq[i] = mk_req(32'h40 + 32'(i), 32'h1111_0000, 4'hF);
      sresp = mk_resp(32'hAAAA_5555);
      step();
      step();
      @(negedge clk);
      total++;
      if (obs_sreq !== '0) begin
        bad++;
        $display("FAIL reset_sreq n=%0d: got %h want 0", n, obs_sreq);
      end
      for (int i = 0; i < n; i++) begin
        total++;
        if (obs_mresp[i] !== '0) begin
          bad++;
          $display("FAIL reset_mresp n=%0d m%0d: got %h want 0", n, i, obs_mresp[i]);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  // T1: one write from m0, slave ready one cycle after the request appears.
  task automatic test_single();
    logic [REQ_W-1:0]  r0;
    logic [RESP_W-1:0] rs;
    int rdy0, m1_nz;
    r0 = mk_req(32'h10, 32'hDEAD_BEEF, 4'hF);
    rs = mk_resp(32'hCAFE_F00D);
    rdy0 = 0;
    m1_nz = 0;
    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      if (c == 0) mreq[0] = r0;
      if (c == 2) sresp = rs;
      if (c == 3) begin mreq[0] = '0; sresp = '0; end
      @(negedge clk);
      total++;
      if (obs_sreq[REQ_W-1] !== ((c == 1) || (c == 2))) begin
        bad++;
        $display("FAIL single_valid c%0d: got %b want %b", c, obs_sreq[REQ_W-1], (c == 1) || (c == 2));
      end
      if (c == 1) begin
        total++;
        if (obs_sreq !== r0) begin
          bad++;
          $display("FAIL single_payload: got %h want %h", obs_sreq, r0);
        end
      end
      if (c == 2) begin
        total++;
        if (obs_mresp[0] !== rs) begin
          bad++;
          $display("FAIL single_resp: got %h want %h", obs_mresp[0], rs);
        end
      end
      if (obs_mresp[0][0] === 1'b1) rdy0++;
      if (obs_mresp[1] !== '0) m1_nz++;
      step();
    end
    total++;
    if (rdy0 !== 1) begin
      bad++;
      $display("FAIL single_ready_count: got %0d want 1", rdy0);
    end
    total++;
    if (m1_nz !== 0) begin
      bad++;
      $display("FAIL single_m1_quiet: got %0d nonzero cycles want 0", m1_nz);
    end
  endtask

  // T2: m0 and m1 together from reset; m0 first, m1 after ready plus one IDLE cycle.
  task automatic test_contention();
    logic [REQ_W-1:0]  r0, r1;
    logic [RESP_W-1:0] ra, rb;
    logic [REQ_W-1:0]  exp_s [5];
    r0 = mk_req(32'h100, 32'h0000_0A0A, 4'h3);
    r1 = mk_req(32'h200, 32'h0000_0B0B, 4'hC);
    ra = mk_resp(32'h1234_5678);
    rb = mk_resp(32'h8765_4321);
    exp_s = '{'0, r0, '0, r1, '0};
    do_reset(2);
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin mreq[0] = r0; mreq[1] = r1; end
        1: sresp = ra;
        2: begin mreq[0] = '0; sresp = '0; end
        3: sresp = rb;
        default: begin mreq[1] = '0; sresp = '0; end
      endcase
      @(negedge clk);
      total++;
      if (obs_sreq !== exp_s[c]) begin
        bad++;
        $display("FAIL contention_sreq c%0d: got %h want %h", c, obs_sreq, exp_s[c]);
      end
      if (c == 1 || c == 3) begin
        total++;
        if (obs_mresp[0] !== ((c == 1) ? ra : '0) || obs_mresp[1] !== ((c == 3) ? rb : '0)) begin
          bad++;
          $display("FAIL contention_route c%0d: got m0=%h m1=%h", c, obs_mresp[0], obs_mresp[1]);
        end
      end
      step();
    end
  endtask

  // T3: three masters permanently valid, slave always ready -> 0,1,2 repeating.
  task automatic test_starvation();
    int          seq [3];
    bit          seen [3];
    int          grants [$];
    logic [31:0] a;
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      seq[i]  = 0;
      mreq[i] = mk_req({16'h0, 8'(i), 8'h00}, 32'($urandom), 4'hF);
    end
    for (int cyc = 0; cyc < 40 && grants.size() < 9; cyc++) begin
      sresp = mk_resp(32'($urandom));
      @(negedge clk);
      if (obs_sreq[REQ_W-1] === 1'b1) begin
        a = req_addr(obs_sreq);
        grants.push_back(int'(a[15:8]));
      end
      for (int i = 0; i < 3; i++) seen[i] = (obs_mresp[i][0] === 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
        if (seen[i]) begin
          seq[i]++;
          mreq[i] = mk_req({16'h0, 8'(i), 8'(seq[i])}, 32'($urandom), 4'hF);
        end
      end
    end
    total++;
    if (grants.size() !== 9) begin
      bad++;
      $display("FAIL starve_count: got %0d grants within budget want 9", grants.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      total++;
      if (grants[k] !== k % 3) begin
        bad++;
        $display("FAIL starve_order k=%0d: got m%0d want m%0d", k, grants[k], k % 3);
      end
    end
    clear_inputs();
    step();
  endtask

  // T4: N=3 with last = 2 after an m2 transaction; only m1 valid must wrap to grant 1.
  task automatic test_wrap();
    logic [REQ_W-1:0]  ra, rb;
    logic [RESP_W-1:0] rs;
    ra = mk_req(32'h0000_0200, 32'h2222_2222, 4'hF);
    rb = mk_req(32'h0000_0100, 32'h1111_1111, 4'h1);
    rs = mk_resp(32'h0BAD_F00D);
    do_reset(3);
    mreq[2] = ra;
    step();
    sresp = mk_resp(32'h0);
    @(negedge clk);
    total++;
    if (obs_sreq !== ra) begin
      bad++;
      $display("FAIL wrap_m2: got %h want %h", obs_sreq, ra);
    end
    step();
    mreq[2] = '0;
    sresp   = '0;
    mreq[1] = rb;
    step();
    sresp = rs;
    @(negedge clk);
    total++;
    if (obs_sreq !== rb) begin
      bad++;
      $display("FAIL wrap_grant1: got %h want %h", obs_sreq, rb);
    end
    total++;
    if (obs_mresp[1] !== rs || obs_mresp[0] !== '0 || obs_mresp[2] !== '0) begin
      bad++;
      $display("FAIL wrap_route: got m0=%h m1=%h m2=%h", obs_mresp[0], obs_mresp[1], obs_mresp[2]);
    end
    step();
    clear_inputs();
    step();
  endtask

  // T5: granted m1 aborts; IDLE follows, late ready is dropped, pending m0 granted.
  task automatic test_abort();
    logic [REQ_W-1:0]  r0, r1;
    logic [RESP_W-1:0] late, rs;
    logic [REQ_W-1:0]  exp_s [6];
    r0   = mk_req(32'h0000_0300, 32'h3030_3030, 4'hF);
    r1   = mk_req(32'h0000_0400, 32'h4040_4040, 4'hF);
    late = mk_resp(32'hFEED_FACE);
    rs   = mk_resp(32'h0101_0101);
    exp_s = '{'0, r1, '0, '0, r0, '0};
    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: mreq[1] = r1;
        1: mreq[0] = r0;
        2: mreq[1] = '0;
        3: sresp = late;
        4: sresp = rs;
        default: begin mreq[0] = '0; sresp = '0; end
      endcase
      @(negedge clk);
      total++;
      if (obs_sreq !== exp_s[c]) begin
        bad++;
        $display("FAIL abort_sreq c%0d: got %h want %h", c, obs_sreq, exp_s[c]);
      end
      if (c == 3) begin
        total++;
        if (obs_mresp[0] !== '0 || obs_mresp[1] !== '0) begin
          bad++;
          $display("FAIL abort_late_ready: got m0=%h m1=%h want 0", obs_mresp[0], obs_mresp[1]);
        end
      end
      if (c == 4) begin
        total++;
        if (obs_mresp[0] !== rs || obs_mresp[1] !== '0) begin
          bad++;
          $display("FAIL abort_m0_resp: got m0=%h m1=%h want m0=%h", obs_mresp[0], obs_mresp[1], rs);
        end
      end
      step();
    end
  endtask

  // T6: reset during an m1 transaction; afterwards m0 wins a simultaneous request.
  task automatic test_reset_busy();
    logic [REQ_W-1:0]  r0, r1;
    logic [RESP_W-1:0] late, rs;
    logic [REQ_W-1:0]  exp_s [6];
    r0   = mk_req(32'h0000_0500, 32'h5050_5050, 4'hF);
    r1   = mk_req(32'h0000_0600, 32'h6060_6060, 4'hF);
    late = mk_resp(32'h7777_7777);
    rs   = mk_resp(32'h9999_9999);
    exp_s = '{'0, r1, r1, '0, r0, r0};
    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: mreq[1] = r1;
        2: rst = 1'b1;
        3: begin rst = 1'b0; mreq[0] = r0; sresp = late; end
        4: sresp = '0;
        5: sresp = rs;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs_sreq !== exp_s[c]) begin
        bad++;
        $display("FAIL rstbusy_sreq c%0d: got %h want %h", c, obs_sreq, exp_s[c]);
      end
      if (c >= 3) begin
        total++;
        if (obs_mresp[0] !== ((c == 5) ? rs : '0) || obs_mresp[1] !== '0) begin
          bad++;
          $display("FAIL rstbusy_resp c%0d: got m0=%h m1=%h", c, obs_mresp[0], obs_mresp[1]);
        end
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  // Random masters (with aborts) and a random-ready slave against a transaction-level model.
  task automatic test_random(int n, int cycles);
    int               owner, powner, last;
    logic [2:0]       pvalid;
    bit               pready;
    bit               pend [3];
    bit               done_prev [3];
    logic [REQ_W-1:0]  exp_s;
    logic [RESP_W-1:0] exp_r;
    do_reset(n);
    owner  = -1;
    powner = -1;
    last   = n - 1;
    pvalid = '0;
    pready = 1'b0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; done_prev[i] = 1'b0; end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < n; i++) begin
        if (pend[i] && done_prev[i]) begin
          pend[i] = 1'b0;
          mreq[i] = '0;
        end else if (pend[i] && $urandom_range(15) == 0) begin
          pend[i] = 1'b0;
          mreq[i] = '0;
        end else if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          mreq[i] = mk_req(32'($urandom), 32'($urandom), 4'($urandom));
        end
      end
      sresp = {32'($urandom), ($urandom_range(2) == 0)};
      if (powner >= 0) owner = (pready || !pvalid[powner]) ? -1 : powner;
      else             owner = rr_pick(pvalid, last, n);
      if (powner >= 0 && owner < 0) last = powner;
      exp_s = (owner >= 0) ? mreq[owner] : '0;
      @(negedge clk);
      total++;
      if (obs_sreq !== exp_s) begin
        bad++;
        $display("FAIL rand%0d_sreq c%0d: got %h want %h", n, c, obs_sreq, exp_s);
      end
      for (int i = 0; i < n; i++) begin
        exp_r = (i == owner) ? sresp : '0;
        total++;
        if (obs_mresp[i] !== exp_r) begin
          bad++;
          $display("FAIL rand%0d_mresp c%0d m%0d: got %h want %h", n, c, i, obs_mresp[i], exp_r);
        end
      end
      for (int i = 0; i < 3; i++) begin
        done_prev[i] = (owner == i) && sresp[0];
        pvalid[i]    = (i < n) ? mreq[i][REQ_W-1] : 1'b0;
      end
      powner = owner;
      pready = sresp[0];
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    rst   = 1'b1;
    n_act = 2;
    clear_inputs();
    step();
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_wrap();
    test_abort();
    test_reset_busy();
    test_random(2, 400);
    test_random(3, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
